// File: rtl/layer_colorizer.sv
// layer_colorizer: composites sprite/bullet layers, world map and ROM images into VGA RGB.
// Optional macro LAYER_COLORIZER_FADE_EN adds a frame-stepped fade-out/fade-in on mode changes.
module layer_colorizer #(
  parameter int          NUM_LAYERS = 4,
  parameter logic [11:0] OBST_COLOR = 12'h840,
  parameter logic [11:0] BG_COLOR   = 12'hFFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [11:0]               pixel_column,
  input  logic [11:0]               pixel_row,
  input  logic                      video_on,
  input  logic                      frame_start,
  input  logic [12*NUM_LAYERS-1:0]  layer_color,
  input  logic [NUM_LAYERS-1:0]     layer_flag,
  input  logic [1:0]                world_pixel,
  input  logic [1:0]                mode_req,
  input  logic                      mode_req_valid,
  output logic                      mode_req_ready,
  output logic [15:0]               rom_addr,
  input  logic [11:0]               rom_data,
  output logic [1:0]                mode_cur,
  output logic [3:0]                VGA_R,
  output logic [3:0]                VGA_G,
  output logic [3:0]                VGA_B
);

  localparam logic [1:0] MODE_GAME = 2'd1;
  localparam logic [4:0] LVL_MAX   = 5'd16;

  function automatic logic [3:0] scale_chan(input logic [3:0] c, input logic [4:0] lvl);
    return 4'((9'(c) * 9'(lvl)) >> 4);
  endfunction

  logic [7:0]  row_q, col_q;
  logic [11:0] game_color;
  logic [11:0] game_color_p0, game_color_p1;
  logic        vld_p0, vld_p1;
  logic [11:0] pix_src, rgb;
  logic [4:0]  level;
  logic [1:0]  mode_pend;
  logic        start_chg;
  logic        unused_wp;

  // Only bit 0 of the map code distinguishes obstacle from background.
  assign unused_wp = world_pixel[1];

  assign row_q = 8'(pixel_row / 12'd3);
  assign col_q = 8'(pixel_column >> 2);

  always_comb begin
    game_color = world_pixel[0] ? OBST_COLOR : BG_COLOR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (layer_flag[k]) game_color = layer_color[12*k +: 12];
    end
  end

  // p0: ROM address issued, sidebands captured
  // p1: sidebands aligned with rom_data returned by the ROM
  always_ff @(posedge clk) begin
    if (reset) begin
      rom_addr      <= '0;
      vld_p0        <= 1'b0;
      vld_p1        <= 1'b0;
      game_color_p0 <= '0;
      game_color_p1 <= '0;
    end else begin
      rom_addr      <= {row_q, col_q};
      vld_p0        <= video_on;
      game_color_p0 <= game_color;
      vld_p1        <= vld_p0;
      game_color_p1 <= game_color_p0;
    end
  end

  always_comb begin
    pix_src = (mode_cur == MODE_GAME) ? game_color_p1 : rom_data;
    rgb     = '0;
    if (vld_p1) begin
      rgb = {scale_chan(pix_src[11:8], level),
             scale_chan(pix_src[7:4],  level),
             scale_chan(pix_src[3:0],  level)};
    end
  end

  assign VGA_R = rgb[11:8];
  assign VGA_G = rgb[7:4];
  assign VGA_B = rgb[3:0];

`ifdef LAYER_COLORIZER_FADE_EN
  typedef enum logic [1:0] {S_IDLE, S_FADE_OUT, S_FADE_IN} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WAIT} state_t;
`endif

  state_t state, state_nxt;

  assign start_chg = mode_req_valid && mode_req_ready && (mode_req != mode_cur);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    mode_req_ready = (state == S_IDLE);
  end

`ifdef LAYER_COLORIZER_FADE_EN
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (start_chg) state_nxt = S_FADE_OUT;
      S_FADE_OUT: if (frame_start && level == 5'd1) state_nxt = S_FADE_IN;
      S_FADE_IN:  if (frame_start && level == 5'd15) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // A frame_start coinciding with the accept is already the first fade step.
  always_ff @(posedge clk) begin
    if (reset) begin
      level     <= LVL_MAX;
      mode_cur  <= 2'd0;
      mode_pend <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_chg) begin
            mode_pend <= mode_req;
            if (frame_start) level <= level - 5'd1;
          end
        end
        S_FADE_OUT: begin
          if (frame_start) begin
            level <= level - 5'd1;
            if (level == 5'd1) mode_cur <= mode_pend;
          end
        end
        S_FADE_IN: begin
          if (frame_start) level <= level + 5'd1;
        end
        default: level <= LVL_MAX;
      endcase
    end
  end
`else
  assign level = LVL_MAX;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_chg) state_nxt = S_WAIT;
      S_WAIT:  if (frame_start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Mode switches on a frame boundary so a frame never shows two images.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_cur  <= 2'd0;
      mode_pend <= 2'd0;
    end else begin
      if (start_chg) mode_pend <= mode_req;
      if (state == S_WAIT && frame_start) mode_cur <= mode_pend;
    end
  end
`endif

endmodule

// File: tb/tb_layer_colorizer.sv
// Scoreboard bench for layer_colorizer; covers both the default and LAYER_COLORIZER_FADE_EN builds.
`timescale 1ns/1ps
module tb_layer_colorizer;
  localparam int NL = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [11:0]       pixel_column, pixel_row;
  logic              video_on, frame_start;
  logic [12*NL-1:0]  layer_color;
  logic [NL-1:0]     layer_flag;
  logic [1:0]        world_pixel, mode_req, mode_cur;
  logic              mode_req_valid, mode_req_ready;
  logic [15:0]       rom_addr;
  logic [11:0]       rom_data;
  logic [3:0]        VGA_R, VGA_G, VGA_B;

  layer_colorizer #(.NUM_LAYERS(NL)) dut (
    .clk(clk), .reset(reset),
    .pixel_column(pixel_column), .pixel_row(pixel_row),
    .video_on(video_on), .frame_start(frame_start),
    .layer_color(layer_color), .layer_flag(layer_flag),
    .world_pixel(world_pixel),
    .mode_req(mode_req), .mode_req_valid(mode_req_valid), .mode_req_ready(mode_req_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .mode_cur(mode_cur),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_word(input logic [15:0] a);
    return (a == 16'h6464) ? 12'hABC : 12'hFFF;
  endfunction

  // Synchronous image ROM, one cycle of read latency
  always @(posedge clk) rom_data <= rom_word(rom_addr);

  typedef struct {
    bit          chk;
    string       tag;
    logic [11:0] exp;
  } ent_t;
  ent_t sbq[$];

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: 0 idle, 1 fade-out, 2 fade-in, 3 waiting for frame
  int         m_state, m_level;
  logic [1:0] m_mode, m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [11:0] model_rgb();
    logic [11:0] src;
    logic [15:0] a;
    bit          found;
    int          r, g, b;
    if (!video_on) return 12'h000;
    a = {8'(pixel_row / 12'd3), 8'(pixel_column / 12'd4)};
    if (m_mode == 2'd1) begin
      src   = world_pixel[0] ? 12'h840 : 12'hFFF;
      found = 0;
      for (int k = 0; k < NL; k++) begin
        if (layer_flag[k] && !found) begin
          src   = layer_color[12*k +: 12];
          found = 1;
        end
      end
    end else begin
      src = rom_word(a);
    end
    r = (int'(src[11:8]) * m_level) / 16;
    g = (int'(src[7:4])  * m_level) / 16;
    b = (int'(src[3:0])  * m_level) / 16;
    return {4'(r), 4'(g), 4'(b)};
  endfunction

  task automatic step(input bit chk, input string tag);
    ent_t e;
    e.chk = chk;
    e.tag = tag;
    e.exp = model_rgb();
    sbq.push_back(e);
    @(posedge clk);
    #1;
    if (sbq.size() == 2) begin
      e = sbq.pop_front();
      if (e.chk) check(e.tag, {VGA_R, VGA_G, VGA_B}, e.exp);
    end
  endtask

  task automatic idle(input int n);
    frame_start    = 1'b0;
    mode_req_valid = 1'b0;
    for (int i = 0; i < n; i++) step(0, "idle");
  endtask

  task automatic model_frame();
    case (m_state)
      1: begin
        m_level--;
        if (m_level == 0) begin
          m_mode  = m_pend;
          m_state = 2;
        end
      end
      2: begin
        m_level++;
        if (m_level == 16) m_state = 0;
      end
      3: begin
        m_mode  = m_pend;
        m_state = 0;
      end
      default: ;
    endcase
  endtask

  task automatic frame_pulse();
    idle(1);
    frame_start = 1'b1;
    step(0, "frame");
    frame_start = 1'b0;
    model_frame();
  endtask

  task automatic request(input logic [1:0] m, input bit with_frame);
    idle(1);
    mode_req       = m;
    mode_req_valid = 1'b1;
    frame_start    = with_frame;
    step(0, "req");
    mode_req_valid = 1'b0;
    frame_start    = 1'b0;
    if (m_state == 0 && m != m_mode) begin
      m_pend = m;
`ifdef LAYER_COLORIZER_FADE_EN
      m_state = 1;
      if (with_frame) m_level--;
`else
      m_state = 3;
`endif
    end else if (with_frame) begin
      model_frame();
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_mode"},  mode_cur, 2'd0);
    check({tag, "_ready"}, mode_req_ready, 1'b1);
    check({tag, "_rgb"},   {VGA_R, VGA_G, VGA_B}, 12'h000);
    check({tag, "_addr"},  rom_addr, 16'h0000);
    reset = 1'b0;
    sbq.delete();
    m_state = 0;
    m_level = 16;
    m_mode  = 2'd0;
    m_pend  = 2'd0;
  endtask

  task automatic pixel(input logic [11:0] row, input logic [11:0] col,
                       input logic [NL-1:0] flags, input logic [1:0] wp,
                       input logic vo, input string tag);
    pixel_row    = row;
    pixel_column = col;
    layer_flag   = flags;
    world_pixel  = wp;
    video_on     = vo;
    step(1, tag);
  endtask

  task automatic game_patterns();
    pixel(12'd5, 12'd7, 4'b0110, 2'b00, 1'b1, "game_l1");
    pixel(12'd5, 12'd8, 4'b0000, 2'b01, 1'b1, "game_obst");
    pixel(12'd5, 12'd9, 4'b0000, 2'b01, 1'b0, "game_blank");
    pixel(12'd6, 12'd9, 4'b0000, 2'b10, 1'b1, "game_bg10");
    pixel(12'd6, 12'd10, 4'b0000, 2'b11, 1'b1, "game_obst11");
    pixel(12'd6, 12'd11, 4'b1000, 2'b01, 1'b1, "game_l3");
    pixel(12'd6, 12'd12, 4'b1111, 2'b00, 1'b1, "game_all");
    pixel(12'd6, 12'd13, 4'b1100, 2'b00, 1'b1, "game_l2");
    idle(2);
  endtask

  initial begin
    reset          = 1'b1;
    pixel_column   = '0;
    pixel_row      = '0;
    video_on       = 1'b1;
    frame_start    = 1'b0;
    layer_color    = {12'hFF0, 12'h00F, 12'h0F0, 12'hF00};
    layer_flag     = '0;
    world_pixel    = 2'b00;
    mode_req       = 2'd0;
    mode_req_valid = 1'b0;
    repeat (2) @(posedge clk);
    do_reset("rst");
    idle(2);

    // Splash image from the ROM
    pixel(12'd300, 12'd400, 4'b0000, 2'b00, 1'b1, "splash_abc");
    check("rom_addr", rom_addr, 16'h6464);
    pixel(12'd10, 12'd20, 4'b0001, 2'b01, 1'b1, "splash_fff");
    pixel(12'd300, 12'd400, 4'b0000, 2'b00, 1'b0, "splash_blank");
    idle(2);
    pixel_row = 12'd0; pixel_column = 12'd0; video_on = 1'b1; layer_flag = '0; world_pixel = 2'b00;

`ifdef LAYER_COLORIZER_FADE_EN
    request(2'd1, 1'b0);
    check("fade_ready_low", mode_req_ready, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      frame_pulse();
      if (i == 8) begin
        pixel(12'd0, 12'd0, 4'b0000, 2'b00, 1'b1, "fade_lvl8");
        idle(2);
      end
    end
    check("fade_mode_cur", mode_cur, 2'd1);
    pixel(12'd0, 12'd0, 4'b0000, 2'b00, 1'b1, "fade_lvl0");
    idle(2);
    for (int i = 0; i < 4; i++) frame_pulse();
    request(2'd2, 1'b0);
    check("fadein_ignored_ready", mode_req_ready, 1'b0);
    for (int i = 0; i < 12; i++) frame_pulse();
    check("fadein_mode_kept", mode_cur, 2'd1);
    check("fade_ready_high", mode_req_ready, 1'b1);
    game_patterns();
    request(2'd1, 1'b0);
    check("same_mode_ready", mode_req_ready, 1'b1);
    request(2'd0, 1'b1);
    pixel(12'd0, 12'd0, 4'b0000, 2'b00, 1'b1, "coincide_lvl15");
    idle(2);
    check("coincide_ready", mode_req_ready, 1'b0);
    frame_pulse();
    frame_pulse();
    pixel(12'd0, 12'd0, 4'b0000, 2'b01, 1'b1, "lvl13_obst");
    idle(2);
    do_reset("mid_fade");
`else
    request(2'd1, 1'b0);
    check("wait_ready_low", mode_req_ready, 1'b0);
    idle(3);
    check("wait_mode_kept", mode_cur, 2'd0);
    pixel(12'd0, 12'd0, 4'b0001, 2'b00, 1'b1, "wait_splash");
    idle(2);
    frame_pulse();
    check("switch_mode", mode_cur, 2'd1);
    check("switch_ready", mode_req_ready, 1'b1);
    game_patterns();
    request(2'd1, 1'b0);
    check("same_mode_ready", mode_req_ready, 1'b1);
    request(2'd3, 1'b0);
    idle(2);
    check("req3_pending", mode_cur, 2'd1);
    frame_pulse();
    check("req3_mode", mode_cur, 2'd3);
    pixel(12'd0, 12'd0, 4'b0000, 2'b00, 1'b1, "req3_full");
    idle(2);
    request(2'd2, 1'b0);
    check("req2_ready_low", mode_req_ready, 1'b0);
    do_reset("mid_wait");
`endif
    pixel(12'd300, 12'd400, 4'b0000, 2'b00, 1'b1, "post_reset_abc");
    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
